ram_r_arbiter: RTL and testbench
================================

RAM_R_ARBITER -- requirements
Module: ram_r_arbiter

Interface
REQ-001 Parameter ADD_WIDTH, default 32, read address width.
REQ-002 Parameter DATA_WIDTH, default 32, read data width.
REQ-003 Parameter BURST_WIDTH_R, default 6, burstcount width.
REQ-004 Parameter BYTE_ENABLE_WIDTH, default 4, byteenable width.
REQ-005 Parameter TAG_DEPTH_LOG2, default 2, log2 of max outstanding bursts.
REQ-006 clk  input  1  single clock; one clock, all logic on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 m0_address/m1_address  input  ADD_WIDTH  requester n burst start address.
REQ-009 m0_read/m1_read  input  1  requester n read command request.
REQ-010 m0_byteenable/m1_byteenable  input  BYTE_ENABLE_WIDTH  requester n byte enables.
REQ-011 m0_burstcount/m1_burstcount  input  BURST_WIDTH_R  requester n burst length, 1..2^BURST_WIDTH_R-1.
REQ-012 m0_waitrequest/m1_waitrequest  output  1  command stall to requester n.
REQ-013 m0_readdatavalid/m1_readdatavalid  output  1  return beat belongs to requester n.
REQ-014 m_readdata  output  DATA_WIDTH  return data, shared by both requesters.
REQ-015 ram_r_address, ram_r_read, ram_r_byteenable, ram_r_burstcount  output  widths as above  memory read command.
REQ-016 ram_r_waitrequest, ram_r_readdatavalid  input  1  memory stall / return beat valid.
REQ-017 ram_r_readdata  input  DATA_WIDTH  memory return data.
REQ-018 err_unexpected  output  1  sticky: beat received with no outstanding burst.

Function
REQ-019 FSM states: IDLE, ISSUE.
REQ-020 IDLE -> ISSUE when (m0_read | m1_read) and tag queue not full: latch grant id; grant rule is round-robin, i.e. the requester not granted last wins a tie.
REQ-021 In ISSUE, ram_r_* command signals are driven combinationally from the granted requester, and granted waitrequest = ram_r_waitrequest.
REQ-022 ISSUE -> IDLE on accept (ram_r_read & !ram_r_waitrequest); same cycle, push {id, burstcount} to the tag queue and record id as last grant.
REQ-023 Non-granted requester, and both requesters in IDLE: waitrequest = 1.
REQ-024 In IDLE: ram_r_read = 0; address, byteenable, burstcount = 0.
REQ-025 Arbitration latency: command appears on ram_r_* the cycle after a request is seen in IDLE. Minimum command-to-command spacing is 2 cycles.
REQ-026 Grant never changes while in ISSUE, even if the granted requester deasserts read. In that case ISSUE -> IDLE without a push.
REQ-027 Queue full (2^TAG_DEPTH_LOG2 entries): FSM stays in IDLE, both waitrequests stay 1.
REQ-028 Return routing: on ram_r_readdatavalid, assert m<head.id>_readdatavalid for that cycle, combinationally. m_readdata = ram_r_readdata always.
REQ-029 Beat counter: loaded from head.burstcount and decremented per beat. Head is popped on its last beat.
REQ-030 Push and pop in the same cycle are both honoured, and occupancy is unchanged.
REQ-031 A burstcount of 0 is treated as 1.
REQ-032 ram_r_readdatavalid with the queue empty: no requester valid is asserted, and err_unexpected is set until rst.

Reset
REQ-033 On rst, immediately:
- FSM = IDLE.
- Tag queue and beat counter are cleared.
- Last grant = 1, so m0 wins the first tie.
- err_unexpected = 0.
- All requester readdatavalid = 0.
- Both waitrequest = 1.
- ram_r_read = 0.
REQ-034 Reset mid-burst discards outstanding tags. Beats arriving after reset release are handled per REQ-032.

Structure
REQ-035 Shared package holds the FSM state typedef, the tag-entry typedef {id, burstcount}, and the TAG_DEPTH constant.
REQ-036 Tag queue is one sub-module, rd_tag_fifo: synchronous push/pop, full/empty flags, same async reset.

Verification
REQ-037 Both requesters read simultaneously, m0 burst 4 @0x100, m1 burst 2 @0x200:
- m0 is issued first, m1 two cycles later.
- Beats route as 4x m0_readdatavalid, then 2x m1_readdatavalid.
REQ-038 m0 requests continuously (burst 1) while m1 is also pending: grants alternate m0, m1, m0, m1.
REQ-039 ram_r_waitrequest held high 5 cycles during ISSUE:
- Command is stable throughout.
- Grant does not change.
- Exactly one tag is pushed.
REQ-040 Memory withholds readdatavalid: after 4 accepted bursts, a 5th request sees waitrequest=1 until the first burst fully returns.
REQ-041 Last beat of the head burst coincides with a new accept: occupancy stays constant, and the next beats route to the correct id.
REQ-042 rst asserted mid-burst (2 of 8 beats returned), then 1 stray beat arrives: no readdatavalid is asserted, and err_unexpected = 1.

Source files
------------

// File: rtl/ram_r_arbiter_pkg.sv
// Shared types for the two-requester burst read arbiter: FSM states, the
// outstanding-burst tag entry and the default tag queue depth.
package ram_r_arbiter_pkg;

    localparam int TAG_DEPTH_LOG2_DEF = 2;
    localparam int TAG_DEPTH          = 1 << TAG_DEPTH_LOG2_DEF;
    // Tag burstcount field is wide enough for any BURST_WIDTH_R up to 16.
    localparam int TAG_BC_W           = 16;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    typedef struct packed {
        logic                id;
        logic [TAG_BC_W-1:0] burstcount;
    } tag_t;

    // A zero-length burst still returns one beat.
    function automatic logic [TAG_BC_W-1:0] eff_beats(input logic [TAG_BC_W-1:0] bc);
        return (bc == '0) ? TAG_BC_W'(1) : bc;
    endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// Outstanding-burst tag queue: records which requester owns each issued burst,
// in issue order, so return beats can be routed back.
module rd_tag_fifo
    import ram_r_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2 = TAG_DEPTH_LOG2_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_data,
    input  logic pop,
    output tag_t head,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    tag_t                  mem_q [DEPTH];
    tag_t                  mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full  = count_q[DEPTH_LOG2];
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ram_r_arbiter.sv
// Two-requester round-robin arbiter onto one burst read port; return beats are
// routed back to the owner of the oldest outstanding burst.
module ram_r_arbiter
    import ram_r_arbiter_pkg::*;
#(
    parameter int ADD_WIDTH         = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BURST_WIDTH_R     = 6,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int TAG_DEPTH_LOG2    = TAG_DEPTH_LOG2_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADD_WIDTH-1:0]         m0_address,
    input  logic                         m0_read,
    input  logic [BYTE_ENABLE_WIDTH-1:0] m0_byteenable,
    input  logic [BURST_WIDTH_R-1:0]     m0_burstcount,
    output logic                         m0_waitrequest,
    output logic                         m0_readdatavalid,
    input  logic [ADD_WIDTH-1:0]         m1_address,
    input  logic                         m1_read,
    input  logic [BYTE_ENABLE_WIDTH-1:0] m1_byteenable,
    input  logic [BURST_WIDTH_R-1:0]     m1_burstcount,
    output logic                         m1_waitrequest,
    output logic                         m1_readdatavalid,
    output logic [DATA_WIDTH-1:0]        m_readdata,
    output logic [ADD_WIDTH-1:0]         ram_r_address,
    output logic                         ram_r_read,
    output logic [BYTE_ENABLE_WIDTH-1:0] ram_r_byteenable,
    output logic [BURST_WIDTH_R-1:0]     ram_r_burstcount,
    input  logic                         ram_r_waitrequest,
    input  logic                         ram_r_readdatavalid,
    input  logic [DATA_WIDTH-1:0]        ram_r_readdata,
    output logic                         err_unexpected
);

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_q, last_d;
    logic [TAG_BC_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                err_q, err_d;

    logic                g_read;
    logic                push, pop;
    tag_t                push_data, head;
    logic                full, empty;
    logic [TAG_BC_W-1:0] cur_beats;

    rd_tag_fifo #(
        .DEPTH_LOG2 (TAG_DEPTH_LOG2)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Command side: grant is latched on IDLE->ISSUE and held until ISSUE exits.
    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        push             = 1'b0;
        push_data        = '0;
        ram_r_read       = 1'b0;
        ram_r_address    = '0;
        ram_r_byteenable = '0;
        ram_r_burstcount = '0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        g_read           = grant_q ? m1_read : m0_read;
        case (state_q)
            IDLE: begin
                if ((m0_read || m1_read) && !full) begin
                    state_d = ISSUE;
                    grant_d = (m0_read && m1_read) ? ~last_q : m1_read;
                end
            end
            ISSUE: begin
                ram_r_read       = g_read;
                ram_r_address    = grant_q ? m1_address    : m0_address;
                ram_r_byteenable = grant_q ? m1_byteenable : m0_byteenable;
                ram_r_burstcount = grant_q ? m1_burstcount : m0_burstcount;
                if (grant_q) m1_waitrequest = ram_r_waitrequest;
                else         m0_waitrequest = ram_r_waitrequest;
                if (!g_read) begin
                    state_d = IDLE;
                end else if (!ram_r_waitrequest) begin
                    state_d              = IDLE;
                    push                 = 1'b1;
                    push_data.id         = grant_q;
                    push_data.burstcount = TAG_BC_W'(ram_r_burstcount);
                    last_d               = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Return side: beat_cnt_q == 0 means the head burst has not started yet.
    always_comb begin
        cur_beats        = (beat_cnt_q == '0) ? eff_beats(head.burstcount) : beat_cnt_q;
        beat_cnt_d       = beat_cnt_q;
        pop              = 1'b0;
        err_d            = err_q;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        if (ram_r_readdatavalid) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                m0_readdatavalid = !head.id;
                m1_readdatavalid = head.id;
                if (cur_beats == TAG_BC_W'(1)) begin
                    pop        = 1'b1;
                    beat_cnt_d = '0;
                end else begin
                    beat_cnt_d = cur_beats - 1'b1;
                end
            end
        end
    end

    assign m_readdata     = ram_r_readdata;
    assign err_unexpected = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ram_r_arbiter.sv
// Self-checking bench for ram_r_arbiter: cycle table for arbitration, hand
// sequences for full queue, stalls, overlap, zero burst and reset, plus a beat scoreboard.
module tb_ram_r_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m1_address;
    logic        m0_read, m1_read;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [5:0]  m0_burstcount, m1_burstcount;
    logic        m0_waitrequest, m1_waitrequest;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m_readdata;
    logic [31:0] ram_r_address;
    logic        ram_r_read;
    logic [3:0]  ram_r_byteenable;
    logic [5:0]  ram_r_burstcount;
    logic        ram_r_waitrequest;
    logic        ram_r_readdatavalid;
    logic [31:0] ram_r_readdata;
    logic        err_unexpected;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } beat_t;
    beat_t exp_q[$];

    typedef struct {
        logic        m0_rd, m1_rd;
        logic [5:0]  m0_bc, m1_bc;
        logic        ram_wait;
        logic        e_read;
        logic [31:0] e_addr;
        logic [5:0]  e_bc;
        logic [3:0]  e_be;
        logic        e_m0w, e_m1w;
    } vec_t;
    vec_t tbl[10];

    always #5 clk = ~clk;

    ram_r_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .m0_address          (m0_address),
        .m0_read             (m0_read),
        .m0_byteenable       (m0_byteenable),
        .m0_burstcount       (m0_burstcount),
        .m0_waitrequest      (m0_waitrequest),
        .m0_readdatavalid    (m0_readdatavalid),
        .m1_address          (m1_address),
        .m1_read             (m1_read),
        .m1_byteenable       (m1_byteenable),
        .m1_burstcount       (m1_burstcount),
        .m1_waitrequest      (m1_waitrequest),
        .m1_readdatavalid    (m1_readdatavalid),
        .m_readdata          (m_readdata),
        .ram_r_address       (ram_r_address),
        .ram_r_read          (ram_r_read),
        .ram_r_byteenable    (ram_r_byteenable),
        .ram_r_burstcount    (ram_r_burstcount),
        .ram_r_waitrequest   (ram_r_waitrequest),
        .ram_r_readdatavalid (ram_r_readdatavalid),
        .ram_r_readdata      (ram_r_readdata),
        .err_unexpected      (err_unexpected)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_read"}, ram_r_read, 0);
        chk({name, "_addr"}, ram_r_address, 0);
        chk({name, "_bc"}, ram_r_burstcount, 0);
        chk({name, "_m0w"}, m0_waitrequest, 1);
        chk({name, "_m1w"}, m1_waitrequest, 1);
    endtask

    // Inputs change only on the falling edge; each call starts a new cycle.
    task automatic cyc();
        @(negedge clk);
        ram_r_readdatavalid = 1'b0;
    endtask

    task automatic drive_beat(input logic id);
        beat_t b;
        ram_r_readdatavalid = 1'b1;
        ram_r_readdata      = $urandom;
        b.id   = id;
        b.data = ram_r_readdata;
        exp_q.push_back(b);
    endtask

    task automatic stray_beat();
        ram_r_readdatavalid = 1'b1;
        ram_r_readdata      = $urandom;
    endtask

    // Scoreboard: every requester-valid beat must match the oldest expected beat.
    always begin
        beat_t b;
        @(negedge clk);
        #2;
        if (m0_readdatavalid || m1_readdatavalid) begin
            checks++;
            if (m0_readdatavalid && m1_readdatavalid) begin
                errors++;
                $display("FAIL rdv_both actual=11 expected=one-hot");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdv_unexpected actual m0=%0b m1=%0b expected none", m0_readdatavalid, m1_readdatavalid);
            end else begin
                b = exp_q.pop_front();
                if (m1_readdatavalid !== b.id || m_readdata !== b.data) begin
                    errors++;
                    $display("FAIL rdv_route actual id=%0d data=%0h expected id=%0d data=%0h",
                             m1_readdatavalid, m_readdata, b.id, b.data);
                end
            end
        end
    end

    initial begin
        //          m0 m1 bc0 bc1 wt  rd addr         bc be    m0w m1w
        tbl[0] = '{1, 1, 4, 2, 0, 0, 32'h0,     0, 4'h0, 1, 1};
        tbl[1] = '{1, 1, 4, 2, 0, 1, 32'h100,   4, 4'hF, 0, 1};
        tbl[2] = '{0, 1, 4, 2, 0, 0, 32'h0,     0, 4'h0, 1, 1};
        tbl[3] = '{0, 1, 4, 2, 0, 1, 32'h200,   2, 4'h3, 1, 0};
        tbl[4] = '{1, 1, 1, 1, 0, 0, 32'h0,     0, 4'h0, 1, 1};
        tbl[5] = '{1, 1, 1, 1, 0, 1, 32'h100,   1, 4'hF, 0, 1};
        tbl[6] = '{1, 1, 1, 1, 0, 0, 32'h0,     0, 4'h0, 1, 1};
        tbl[7] = '{1, 1, 1, 1, 0, 1, 32'h200,   1, 4'h3, 1, 0};
        tbl[8] = '{1, 0, 1, 1, 0, 0, 32'h0,     0, 4'h0, 1, 1};
        tbl[9] = '{1, 0, 1, 1, 0, 0, 32'h0,     0, 4'h0, 1, 1};

        rst = 1'b1;
        m0_address = 32'h100; m1_address = 32'h200;
        m0_byteenable = 4'hF; m1_byteenable = 4'h3;
        m0_read = 0; m1_read = 0; m0_burstcount = 0; m1_burstcount = 0;
        ram_r_waitrequest = 0; ram_r_readdatavalid = 0; ram_r_readdata = 0;

        repeat (2) cyc();
        #1;
        chk_idle("reset");
        chk("reset_err", err_unexpected, 0);
        chk("reset_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        cyc();
        rst = 1'b0;

        // Arbitration: simultaneous start, then alternation until the queue fills.
        for (int i = 0; i < 10; i++) begin
            cyc();
            m0_read = tbl[i].m0_rd; m1_read = tbl[i].m1_rd;
            m0_burstcount = tbl[i].m0_bc; m1_burstcount = tbl[i].m1_bc;
            ram_r_waitrequest = tbl[i].ram_wait;
            #1;
            chk($sformatf("vec%0d_read", i), ram_r_read, tbl[i].e_read);
            chk($sformatf("vec%0d_addr", i), ram_r_address, tbl[i].e_addr);
            chk($sformatf("vec%0d_bc", i), ram_r_burstcount, tbl[i].e_bc);
            chk($sformatf("vec%0d_be", i), ram_r_byteenable, tbl[i].e_be);
            chk($sformatf("vec%0d_m0w", i), m0_waitrequest, tbl[i].e_m0w);
            chk($sformatf("vec%0d_m1w", i), m1_waitrequest, tbl[i].e_m1w);
        end

        // Full queue: m0 stays stalled until the 4-beat head burst drains.
        m0_burstcount = 6'd3;
        for (int k = 0; k < 4; k++) begin
            cyc();
            drive_beat(0);
            #1;
            chk($sformatf("full_hold%0d_m0w", k), m0_waitrequest, 1);
            chk($sformatf("full_hold%0d_read", k), ram_r_read, 0);
        end
        cyc();
        drive_beat(1);
        #1;
        chk("full_release_read", ram_r_read, 0);
        chk("full_release_m0w", m0_waitrequest, 1);
        // Last beat of head burst lands in the same cycle as a new accept.
        cyc();
        drive_beat(1);
        #1;
        chk("overlap_read", ram_r_read, 1);
        chk("overlap_addr", ram_r_address, 32'h100);
        chk("overlap_bc", ram_r_burstcount, 3);
        chk("overlap_m0w", m0_waitrequest, 0);
        cyc();
        m0_read = 0;
        drive_beat(0);
        cyc(); drive_beat(1);
        for (int k = 0; k < 3; k++) begin
            cyc(); drive_beat(0);
        end
        cyc();
        #3;
        chk("drain1_empty", exp_q.size(), 0);

        // Granted requester withdraws in ISSUE: back to IDLE, nothing queued.
        cyc();
        m0_read = 1; m0_burstcount = 1;
        #1;
        chk_idle("withdraw_pre");
        cyc();
        m0_read = 0;
        #1;
        chk("withdraw_read", ram_r_read, 0);

        // Memory stall for 5 cycles with both requesting: m1 holds the grant.
        cyc();
        m0_read = 1; m1_read = 1; m1_burstcount = 5; ram_r_waitrequest = 1;
        #1;
        chk_idle("stall_pre");
        for (int k = 0; k < 5; k++) begin
            cyc();
            #1;
            chk($sformatf("stall%0d_read", k), ram_r_read, 1);
            chk($sformatf("stall%0d_addr", k), ram_r_address, 32'h200);
            chk($sformatf("stall%0d_bc", k), ram_r_burstcount, 5);
            chk($sformatf("stall%0d_m0w", k), m0_waitrequest, 1);
            chk($sformatf("stall%0d_m1w", k), m1_waitrequest, 1);
        end
        cyc();
        ram_r_waitrequest = 0;
        #1;
        chk("stall_accept_addr", ram_r_address, 32'h200);
        chk("stall_accept_m1w", m1_waitrequest, 0);
        cyc();
        m0_read = 0; m1_read = 0;
        for (int k = 0; k < 5; k++) begin
            cyc(); drive_beat(1);
        end
        // Only one tag may exist: an extra beat must be flagged, not routed.
        cyc();
        stray_beat();
        #1;
        chk("stray1_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        chk("stray1_err_pre", err_unexpected, 0);
        cyc();
        #1;
        chk("stray1_err", err_unexpected, 1);

        // Zero-length burst from m1 returns one beat, then m0 burst 8 cut by reset.
        cyc();
        m1_read = 1; m1_burstcount = 0;
        cyc();
        #1;
        chk("zero_bc_read", ram_r_read, 1);
        chk("zero_bc_addr", ram_r_address, 32'h200);
        cyc();
        m1_read = 0; m0_read = 1; m0_burstcount = 8;
        cyc();
        #1;
        chk("b8_read", ram_r_read, 1);
        chk("b8_bc", ram_r_burstcount, 8);
        cyc();
        m0_read = 0;
        drive_beat(1);
        cyc(); drive_beat(0);
        cyc(); drive_beat(0);
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        chk("midrst_err", err_unexpected, 0);
        chk("midrst_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        cyc();
        rst = 1'b0;
        cyc();
        stray_beat();
        #1;
        chk("stray2_rdv", {m0_readdatavalid, m1_readdatavalid}, 0);
        cyc();
        #3;
        chk("stray2_err", err_unexpected, 1);
        chk("final_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
